// File: rtl/tx_medida_ascii.sv
`timescale 1ns/1ps
// tx_medida_ascii
//   Sends a 3-digit BCD distance as an ASCII string ("ddd#") on a 7O1 serial
//   line, LSB first. Non-decimal nibbles are sent as '?'.
//   Optional build macro TX_CRLF_EN appends CR LF after the '#'.
//
// Parameters:
//   DIV           clock cycles per serial bit (>= 2)
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   inicio        start request, honoured only while idle (OCIOSO)
//   dados         BCD measurement [11:8] hundreds, [7:4] tens, [3:0] units
//   saida_serial  serial line, idles high
//   pronto        one-cycle pulse after the last stop bit
//   ocupado       high while a string is being loaded/sent, including pronto
//   db_estado     FSM state code for debug display
module tx_medida_ascii #(
  parameter int unsigned DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [11:0] dados,
  output logic        saida_serial,
  output logic        pronto,
  output logic        ocupado,
  output logic [3:0]  db_estado
);

  localparam int unsigned TW = $clog2(DIV);
`ifdef TX_CRLF_EN
  localparam logic [2:0] ULTIMO = 3'd5;
`else
  localparam logic [2:0] ULTIMO = 3'd3;
`endif

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    CARREGA   = 4'd1,
    TRANSMITE = 4'd2,
    PROXIMO   = 4'd3,
    FIM       = 4'd4
  } estado_t;

  estado_t       estado, prox_estado;
  logic          pedido;
  logic [11:0]   medida;
  logic [TW-1:0] tick;
  logic [3:0]    bit_idx;
  logic [2:0]    char_idx;
  logic [6:0]    caractere;
  logic [9:0]    quadro;
  logic          fim_bit, fim_quadro, ultimo_char;

  function automatic logic [6:0] digito(input logic [3:0] n);
    return (n > 4'd9) ? 7'h3F : {3'b011, n};
  endfunction

  assign fim_bit     = (tick == TW'(DIV - 1));
  assign fim_quadro  = fim_bit && (bit_idx == 4'd9);
  assign ultimo_char = (char_idx == ULTIMO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox_estado;
  end

  // The start request is registered while idle, which gives the
  // inicio -> CARREGA -> start-bit latency of two edges.
  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:    if (pedido) prox_estado = CARREGA;
      CARREGA:   prox_estado = TRANSMITE;
      TRANSMITE: if (fim_quadro && ultimo_char) prox_estado = FIM;
      PROXIMO:   prox_estado = TRANSMITE;
      FIM:       prox_estado = OCIOSO;
      default:   prox_estado = OCIOSO;
    endcase
  end

  // PROXIMO never holds a cycle: the character index advances on the
  // stop-bit wrap while staying in TRANSMITE, so frames abut with no gap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pedido   <= 1'b0;
      medida   <= '0;
      tick     <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
    end else begin
      pedido <= inicio && (estado == OCIOSO);
      case (estado)
        CARREGA: begin
          medida   <= dados;
          tick     <= '0;
          bit_idx  <= '0;
          char_idx <= '0;
        end
        TRANSMITE: begin
          if (fim_bit) begin
            tick <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx  <= '0;
              char_idx <= char_idx + 3'd1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: begin
          tick     <= '0;
          bit_idx  <= '0;
          char_idx <= '0;
        end
      endcase
    end
  end

  always_comb begin
    caractere = 7'h23;
    case (char_idx)
      3'd0:    caractere = digito(medida[11:8]);
      3'd1:    caractere = digito(medida[7:4]);
      3'd2:    caractere = digito(medida[3:0]);
      3'd3:    caractere = 7'h23;
`ifdef TX_CRLF_EN
      3'd4:    caractere = 7'h0D;
      3'd5:    caractere = 7'h0A;
`endif
      default: caractere = 7'h23;
    endcase
  end

  // stop, odd parity, data LSB first, start
  assign quadro = {1'b1, ~^caractere, caractere, 1'b0};

  always_comb begin
    saida_serial = 1'b1;
    pronto       = (estado == FIM);
    ocupado      = (estado != OCIOSO);
    db_estado    = estado;
    if (estado == TRANSMITE) saida_serial = quadro[bit_idx];
  end

endmodule

// File: tb/tb_tx_medida_ascii.sv
`timescale 1ns/1ps
module tb_tx_medida_ascii;

  localparam int DIV = 4;
  localparam int FRAME_CYC = 10 * DIV;
`ifdef TX_CRLF_EN
  localparam int NC = 6;
  localparam int PRONTO_LAT = 242;
`else
  localparam int NC = 4;
  localparam int PRONTO_LAT = 162;
`endif

  logic        clock = 1'b0;
  logic        reset, inicio;
  logic [11:0] dados;
  logic        saida_serial, pronto, ocupado;
  logic [3:0]  db_estado;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t0 = -1000000;
  logic [11:0] lat = '0;
  logic [9:0]  got [6];
  int          tin, k, pc;

  always #5 clock = ~clock;

  tx_medida_ascii #(.DIV(DIV)) dut (
    .clock(clock), .reset(reset), .inicio(inicio), .dados(dados),
    .saida_serial(saida_serial), .pronto(pronto), .ocupado(ocupado),
    .db_estado(db_estado)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: string content from the character rules.
  function automatic logic [7:0] char_of(input int idx, input logic [11:0] d);
    int nib;
    case (idx)
      0, 1, 2: begin
        nib = int'((d >> (4 * (2 - idx))) & 12'hF);
        return (nib < 10) ? 8'(48 + nib) : 8'h3F;
      end
      3: return 8'h23;
      4: return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Line level k cycles after the first start bit of a string.
  function automatic logic line_bit(input int kk, input logic [11:0] d);
    int b;
    logic [7:0] c;
    b = (kk / DIV) % 10;
    c = char_of(kk / FRAME_CYC, d);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    if (b == 8) return ($countones(c[6:0]) % 2 == 0);
    return c[b-1];
  endfunction

  // Timeline model: accepted start edge t0, data taken two edges later.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      t0 = -1000000;
    end else begin
      cyc = cyc + 1;
      if (inicio && cyc >= t0 + 2 + NC * FRAME_CYC + 2) t0 = cyc;
      if (cyc == t0 + 2) lat = dados;
    end
  end

  always @(negedge clock) begin : comparador
    int fim;
    logic el, ep, eo;
    logic [3:0] ed;
    fim = t0 + 2 + NC * FRAME_CYC;
    el = 1'b1; ep = 1'b0; eo = 1'b0; ed = 4'd0;
    if (cyc == t0 + 1) begin
      eo = 1'b1; ed = 4'd1;
    end else if (cyc >= t0 + 2 && cyc < fim) begin
      eo = 1'b1; ed = 4'd2; el = line_bit(cyc - t0 - 2, lat);
    end else if (cyc == fim) begin
      eo = 1'b1; ed = 4'd4; ep = 1'b1;
    end
    chk("linha", saida_serial, el);
    chk("pronto", pronto, ep);
    chk("ocupado", ocupado, eo);
    chk("db_estado", db_estado, ed);
  end

  task automatic pulse(input logic [11:0] d);
    @(negedge clock);
    dados = d; inicio = 1'b1;
    @(posedge clock);
    #1 tin = cyc;
    @(negedge clock);
    inicio = 1'b0;
  endtask

  task automatic recv(output int ks);
    ks = -1;
    for (int i = 0; i < 20 && ks < 0; i++) begin
      @(negedge clock);
      if (saida_serial === 1'b0) ks = cyc;
    end
    if (ks < 0) begin
      chk("start_timeout", 0, 1);
    end else begin
      for (int i = 0; i < NC * 10; i++) begin
        while (cyc < ks + i * DIV + 1) @(negedge clock);
        got[i / 10][i % 10] = saida_serial;
      end
    end
  endtask

  task automatic wait_pronto(output int p);
    p = -1;
    for (int i = 0; i < 400 && p < 0; i++) begin
      @(negedge clock);
      if (pronto === 1'b1) p = cyc;
    end
    if (p < 0) chk("pronto_timeout", 0, 1);
  endtask

  task automatic chk_char(input int idx, input logic [7:0] c, input logic p);
    chk($sformatf("quadro%0d", idx), got[idx], {1'b1, p, c[6:0], 1'b0});
  endtask

  task automatic check_str(input logic [7:0] c0, input logic p0, input logic [7:0] c1,
                           input logic p1, input logic [7:0] c2, input logic p2);
    chk_char(0, c0, p0);
    chk_char(1, c1, p1);
    chk_char(2, c2, p2);
    chk_char(3, 8'h23, 1'b0);
`ifdef TX_CRLF_EN
    chk_char(4, 8'h0D, 1'b0);
    chk_char(5, 8'h0A, 1'b1);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; inicio = 1'b0; dados = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_linha", saida_serial, 1);
    chk("rst_ocupado", ocupado, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // basic string, re-pulse and data change mid-string, inicio in FIM cycle
    pulse(12'h123);
    fork
      recv(k);
      begin
        repeat (FRAME_CYC + 8) @(negedge clock);
        inicio = 1'b1; dados = 12'h777;
        @(negedge clock);
        inicio = 1'b0;
      end
    join
    chk("lat_start", k - tin, 2);
    check_str(8'h31, 0, 8'h32, 0, 8'h33, 1);
    wait_pronto(pc);
    chk("lat_pronto", pc - tin, PRONTO_LAT);
    inicio = 1'b1;
    @(negedge clock);
    inicio = 1'b0;
    repeat (5) @(negedge clock);
    chk("fim_ign_db", db_estado, 0);
    chk("fim_ign_linha", saida_serial, 1);

    // invalid digit, then back-to-back start
    pulse(12'h9A5);
    recv(k);
    check_str(8'h39, 1, 8'h3F, 1, 8'h35, 1);
    wait_pronto(pc);
    pulse(12'h123);
    recv(k);
    chk("b2b_start", k - pc, 4);
    check_str(8'h31, 0, 8'h32, 0, 8'h33, 1);
    wait_pronto(pc);

    // asynchronous reset during tens-digit data bit 0
    repeat (2) @(negedge clock);
    pulse(12'h123);
    while (cyc < tin + 2 + FRAME_CYC + DIV + 1) @(negedge clock);
    chk("pre_rst_linha", saida_serial, 0);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_linha", saida_serial, 1);
    chk("async_rst_ocupado", ocupado, 0);
    chk("async_rst_db", db_estado, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    pulse(12'h045);
    recv(k);
    chk("pos_rst_start", k - tin, 2);
    check_str(8'h30, 1, 8'h34, 0, 8'h35, 1);
    wait_pronto(pc);

`ifdef TX_CRLF_EN
    pulse(12'h100);
    recv(k);
    check_str(8'h31, 0, 8'h30, 1, 8'h30, 1);
    wait_pronto(pc);
    chk("crlf_pronto", pc - tin, 242);
`endif

    // random requests and data changes; the model judges every cycle
    repeat (3000) begin
      @(negedge clock);
      inicio = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) dados = 12'($urandom);
    end
    @(negedge clock);
    inicio = 1'b0;
    repeat (NC * FRAME_CYC + 10) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_medida_ascii.md
Name: tx_medida_ascii

Overview:
- Downstream consumer of the HC-SR04 interface measurement.
- Takes a 3-digit BCD distance (hundreds, tens, units) and a start pulse.
- Transmits the distance as an ASCII string terminated by '#' over a single asynchronous serial line, 7 data bits, odd parity, 1 stop bit (7O1), LSB first.
- Feeds the board's serial output pin and raises a one-cycle `pronto` when the whole string has left the line.

Parameters:
- DIV, 434, clock cycles per serial bit (50 MHz / 115200 baud); must be ≥ 2.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- inicio  input  1  start request, sampled only in state OCIOSO
- dados  input  12  BCD measurement: [11:8] hundreds, [7:4] tens, [3:0] units
- saida_serial  output  1  serial line, idles high
- pronto  output  1  one-cycle pulse after the last stop bit of the string
- ocupado  output  1  high from the cycle after `inicio` is accepted until `pronto` inclusive
- db_estado  output  4  FSM state code for 7-segment debug

Behaviour:
- **Reset** (`reset`=0, asynchronous):
  - Outputs: `saida_serial`=1, `pronto`=0, `ocupado`=0, `db_estado`=0.
  - Counters: all cleared.
  - An active reset mid-frame forces the line high immediately and aborts the string.
- **FSM states** (`db_estado` code):
  - OCIOSO(0): line high; `inicio`=1 → CARREGA.
  - CARREGA(1): latch `dados` into an internal register; character index = 0 → TRANSMITE.
  - TRANSMITE(2): shift out the 10-bit frame of the current character, DIV cycles per bit. After the stop bit's DIV-th cycle:
    - if more characters remain → PROXIMO;
    - otherwise → FIM.
  - PROXIMO(3): increment the character index, build the next frame. Does not consume a clock: the frame build is combinational, so the next start bit follows the previous stop bit with no gap. PROXIMO is encoded but transparent in timing.
  - FIM(4): `pronto`=1 for exactly one cycle → OCIOSO.
- **Latency**: `inicio` sampled high at edge N → CARREGA at N+1 → start bit driven from edge N+2.
- **Frame**:
  - Bit order: start(0), d0..d6, parity, stop(1).
  - Parity is odd: the number of ones in d0..d6 plus the parity bit is odd.
- **Character sequence**: hundreds, tens, units, '#' (0x23).
- **Digit encoding**:
  - Valid digit 0–9 → ASCII {3'b011, digit} (0x30–0x39).
  - Nibble > 9 → '?' (0x3F).
- **Timing**: string duration = 4 × 10 × DIV cycles. `pronto` is high in the cycle immediately after the last stop bit ends.
- **Input handling**:
  - `inicio` is ignored in every state except OCIOSO, including the FIM cycle.
  - `dados` changing after CARREGA has no effect on the string in flight.
- **Bit timer**: counts 0..DIV-1 and wraps at DIV-1. The bit index advances on the wrap.

Optional Feature:
- Macro `TX_CRLF_EN`.
- **Defined**: after '#', two further characters are sent: CR (0x0D) and LF (0x0A), same 7O1 framing. The string is 6 characters, 60 × DIV cycles, and `pronto` follows the LF stop bit.
- **Undefined**: the string ends at '#' (4 characters).
- States and `db_estado` codes are identical in both builds.

Test Plan (DIV=4, macro undefined unless stated):
- **Basic string**: reset low 3 cycles then high; `dados`=12'h123, `inicio` pulse 1 cycle.
  - Line carries 0x31 (parity 0), 0x32 (parity 0), 0x33 (parity 1), 0x23 (parity 0), each bit 4 cycles.
  - Start bit begins 2 edges after `inicio`.
  - `pronto` is a single pulse 162 edges after `inicio`; `ocupado` is high throughout.
- **Invalid digit**: `dados`=12'h9A5.
  - Characters are 0x39 (parity 1), 0x3F (parity 1), 0x35 (parity 1), 0x23.
- **Ignored inputs**:
  - Re-pulse `inicio` and change `dados` to 12'h777 during the second character: no restart, still 12'h123 output, exactly one `pronto`.
  - Pulse `inicio` in the FIM cycle: ignored, line stays high.
- **Mid-frame reset**: assert reset during the tens-digit data bits.
  - `saida_serial` goes to 1 without waiting for a clock; `ocupado`=0, `db_estado`=0.
  - After release, a new `inicio` with 12'h045 transmits 0x30, 0x34, 0x35, 0x23 correctly.
- **Back-to-back strings**: `inicio` pulse in the first OCIOSO cycle after `pronto`.
  - Second string starts 2 edges later; no glitch low on the line between strings.
- **`TX_CRLF_EN` defined**: `dados`=12'h100.
  - Characters are 0x31, 0x30, 0x30, 0x23, 0x0D (parity 0), 0x0A (parity 1).
  - `pronto` 242 edges after `inicio`.
